adc_9226_capture: RTL and testbench
===================================

ADC_9226_CAPTURE -- requirements
Module: adc_9226_capture

Interface
REQ-001 Parameter ADC_W, default 12: ADC sample width.
REQ-002 Parameter PIPE_LAT, default 7: ADC pipeline latency, in clk cycles.
REQ-003 Parameter ACC_LOG2, default 2, range 0..4: log2 of samples averaged per output word.
REQ-004 clk  in  1: sole clock; ADC sample clock source.
REQ-005 rst  in  1: synchronous, active-high reset.
REQ-006 I_en  in  1: capture enable.
REQ-007 I_adc_data  in  ADC_W: ADC parallel data, offset binary.
REQ-008 I_adc_otr  in  1: ADC out-of-range flag, aligned with I_adc_data.
REQ-009 I_ready  in  1: downstream accept.
REQ-010 O_adc_clkDriver  out  1: ADC clock, combinational copy of clk.
REQ-011 O_data  out  ADC_W: averaged sample, offset binary.
REQ-012 O_valid  out  1: O_data valid.
REQ-013 O_otr  out  1: OTR seen in any sample of the window that produced O_data; qualified by O_valid.
REQ-014 O_overrun  out  1: sticky; an output word was dropped.
REQ-015 O_busy  out  1: state is not IDLE.

Function
REQ-016 I_adc_data and I_adc_otr SHALL be registered on rising clk before any use; this is one input stage.
REQ-017 The FSM SHALL have states IDLE, FILL and RUN.
REQ-018 IDLE -> FILL SHALL occur on the first cycle I_en=1.
REQ-019 FILL SHALL discard exactly PIPE_LAT registered samples, then enter RUN.
REQ-020 Any state -> IDLE SHALL occur on the cycle I_en=0; the partial accumulator and window count are cleared; a pending O_valid word is kept.
REQ-021 RUN SHALL accumulate each registered sample into an accumulator of width ADC_W+ACC_LOG2, unsigned, with no saturation.
REQ-022 RUN SHALL OR-accumulate the registered OTR flags.
REQ-023 After 2^ACC_LOG2 samples, the window result SHALL be acc >> ACC_LOG2 (truncating), with the OR of the window's OTR flags.
REQ-024 The accumulator SHALL restart on the cycle after window completion, with no dead cycle; the next sample seeds it directly.
REQ-025 Output register, at window completion: if O_valid=0, or O_valid=1 and I_ready=1 in that cycle, it SHALL load the result and assert O_valid.
REQ-026 Otherwise the result SHALL be dropped, O_data/O_otr held, and O_overrun set.
REQ-027 O_valid SHALL clear on the cycle after O_valid=1 and I_ready=1, unless reloaded in the same cycle (REQ-025).
REQ-028 With ACC_LOG2=0, every RUN sample SHALL be one output word.
REQ-029 Latency with ACC_LOG2=0: O_valid SHALL rise 2 clk after the sample edge that captured the corresponding data (input stage + output register).
REQ-030 O_overrun SHALL clear only on rst.
REQ-031 Throughput: one output word per 2^ACC_LOG2 cycles in RUN, sustained while I_ready=1.

Reset
REQ-032 On rst=1 at a rising clk: state=IDLE; accumulator, window count, FILL count and input register = 0; O_data=0, O_valid=0, O_otr=0, O_overrun=0, O_busy=0.
REQ-033 rst SHALL take priority over I_en and I_ready in the same cycle.
REQ-034 rst mid-RUN SHALL discard all in-flight data; after release, FILL SHALL be repeated.
REQ-035 O_adc_clkDriver SHALL remain toggling during rst.

Structure
REQ-036 Package adc_pkg SHALL hold the state encoding constants and the defaults for ADC_W and PIPE_LAT; the package is shared with dac_* drivers.
REQ-037 The accumulate/divide/OTR-OR datapath SHALL be sub-module adc_avg_acc (params ADC_W, ACC_LOG2; ports clk, rst, clr, in_vld, in_data, in_otr, out_vld, out_data, out_otr).
REQ-038 No vendor primitives; all logic on clk rising edge.

Verification
REQ-039 ACC_LOG2=2, I_ready=1, I_en raised: data 100,104,108,112 after FILL -> O_data=106, O_valid for 1 cycle, O_otr=0.
REQ-040 ACC_LOG2=0: I_en rises at cycle 0 -> first 7 registered samples discarded; the 8th registered sample appears on O_data with O_valid=1, 2 clk after its capture edge.
REQ-041 ACC_LOG2=2: one window with OTR=1 on 3rd sample, data 4095 x4 -> O_data=4095, O_otr=1; next clean window -> O_otr=0.
REQ-042 ACC_LOG2=0, I_ready=0 for 3 samples in RUN -> first word held unchanged, O_overrun=1 stays 1 after I_ready returns until rst.
REQ-043 I_en dropped after 2 of 4 window samples, then re-raised -> no output from the partial window, FILL repeated, next word averages only new samples.
REQ-044 rst asserted mid-RUN with O_valid=1 -> next cycle all outputs 0, O_busy=0.

Source files
------------

// File: rtl/adc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_pkg
// Description : Shared constants for the AD9226 capture path and the dac_*
//               drivers: FSM state encoding, default converter width and
//               pipeline latency, and a counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_pkg;

    // FSM state encoding (explicit 2-bit width)
    localparam int unsigned              c_STATE_W = 2;
    localparam logic [c_STATE_W-1:0]     c_ST_IDLE = 2'd0;
    localparam logic [c_STATE_W-1:0]     c_ST_FILL = 2'd1;
    localparam logic [c_STATE_W-1:0]     c_ST_RUN  = 2'd2;

    // Converter defaults (AD9226: 12 bit, 7-clock pipeline)
    localparam int unsigned c_ADC_W_DEFAULT    = 12;
    localparam int unsigned c_PIPE_LAT_DEFAULT = 7;

    // Number of bits needed to hold the values 0..max_val, never less than 1.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = 1;
        while ((max_val >> w) != 0) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_avg_acc.sv
`default_nettype none
// ============================================================================
// Module      : adc_avg_acc
// Description : Window averager. Sums 2^ACC_LOG2 consecutive valid samples,
//               ORs their out-of-range flags, and emits a one-cycle result
//               of sum >> ACC_LOG2 (truncating) with the OR'd flag.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               clr           - abandon the partial window
//               in_vld        - in_data/in_otr carry a sample to accumulate
//               in_data/in_otr- sample and its out-of-range flag
//               out_vld       - one-cycle strobe, window result ready
//               out_data/otr  - averaged sample and window OTR OR
// Revision    : 1.0 - initial release
// ============================================================================
module adc_avg_acc
    import adc_pkg::*;
#(
    parameter int unsigned ADC_W    = c_ADC_W_DEFAULT,
    parameter int unsigned ACC_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_vld,
    input  logic [ADC_W-1:0] in_data,
    input  logic             in_otr,
    output logic             out_vld,
    output logic [ADC_W-1:0] out_data,
    output logic             out_otr
);

    // The sum of 2^ACC_LOG2 unsigned ADC_W-bit samples always fits in
    // ADC_W+ACC_LOG2 bits, so no saturation logic is needed.
    localparam int unsigned          c_ACC_W = ADC_W + ACC_LOG2;
    localparam int unsigned          c_CNT_W = (ACC_LOG2 > 0) ? ACC_LOG2 : 1;
    localparam logic [c_CNT_W-1:0]   c_LAST  = c_CNT_W'((1 << ACC_LOG2) - 1);

    logic [c_ACC_W-1:0] r_acc;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_otr;
    logic               r_out_vld;
    logic [ADC_W-1:0]   r_out_data;
    logic               r_out_otr;

    logic [c_ACC_W-1:0] w_sum;
    logic               w_otr_any;
    logic               w_last;

    // Sum and flag including the sample being presented this cycle, so the
    // final sample of a window goes straight into the result.
    assign w_sum     = r_acc + c_ACC_W'(in_data);
    assign w_otr_any = r_otr | in_otr;
    assign w_last    = (r_cnt == c_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_otr      <= 1'b0;
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
            r_out_otr  <= 1'b0;
        end else begin
            r_out_vld <= 1'b0;
            if (clr) begin
                r_acc <= '0;
                r_cnt <= '0;
                r_otr <= 1'b0;
            end else if (in_vld) begin
                if (w_last) begin
                    // Window complete: publish and restart from zero so the
                    // very next sample seeds a fresh window.
                    r_out_vld  <= 1'b1;
                    r_out_data <= w_sum[c_ACC_W-1:ACC_LOG2];
                    r_out_otr  <= w_otr_any;
                    r_acc      <= '0;
                    r_cnt      <= '0;
                    r_otr      <= 1'b0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    r_otr <= w_otr_any;
                end
            end
        end
    end

    assign out_vld  = r_out_vld;
    assign out_data = r_out_data;
    assign out_otr  = r_out_otr;

endmodule
`default_nettype wire

// File: rtl/adc_9226_capture.sv
`default_nettype none
// ============================================================================
// Module      : adc_9226_capture
// Description : AD9226 parallel-ADC capture front end. Registers the ADC bus,
//               discards the converter's pipeline-latency samples after each
//               enable, averages 2^ACC_LOG2 samples per output word and
//               presents the result through a valid/ready output register
//               with a sticky overrun flag.
// Ports       : clk, rst          - clock (also ADC clock), sync reset
//               I_en              - capture enable
//               I_adc_data/otr    - ADC data (offset binary) and OTR flag
//               I_ready           - downstream accept
//               O_adc_clkDriver   - clock forwarded to the ADC
//               O_data/O_otr      - averaged word and window OTR OR
//               O_valid           - O_data/O_otr valid
//               O_overrun         - sticky, a finished word was dropped
//               O_busy            - FSM not idle
// Revision    : 1.0 - initial release
// ============================================================================
module adc_9226_capture
    import adc_pkg::*;
#(
    parameter int unsigned ADC_W    = c_ADC_W_DEFAULT,
    parameter int unsigned PIPE_LAT = c_PIPE_LAT_DEFAULT,
    parameter int unsigned ACC_LOG2 = 2   // 0..4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             I_en,
    input  logic [ADC_W-1:0] I_adc_data,
    input  logic             I_adc_otr,
    input  logic             I_ready,
    output logic             O_adc_clkDriver,
    output logic [ADC_W-1:0] O_data,
    output logic             O_valid,
    output logic             O_otr,
    output logic             O_overrun,
    output logic             O_busy
);

    localparam int unsigned        c_FILL_W    = cnt_width(PIPE_LAT);
    // Only meaningful when PIPE_LAT > 0; FILL is skipped otherwise.
    localparam logic [c_FILL_W-1:0] c_FILL_LAST = c_FILL_W'(PIPE_LAT - 1);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_next_state;
    logic [c_FILL_W-1:0]  r_fill_cnt;

    logic [ADC_W-1:0]     r_adc_data;
    logic                 r_adc_otr;

    logic                 w_fill_step;
    logic                 w_run_step;
    logic                 w_busy;
    logic                 w_acc_clr;

    logic                 w_win_vld;
    logic [ADC_W-1:0]     w_win_data;
    logic                 w_win_otr;

    logic [ADC_W-1:0]     r_o_data;
    logic                 r_o_valid;
    logic                 r_o_otr;
    logic                 r_o_overrun;

    // The ADC runs from the same clock; forward it untouched so it keeps
    // toggling through reset.
    assign O_adc_clkDriver = clk;

    // ------------------------------------------------------------------
    // Input stage: nothing downstream looks at the raw ADC pins.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_adc_data <= '0;
            r_adc_otr  <= 1'b0;
        end else begin
            r_adc_data <= I_adc_data;
            r_adc_otr  <= I_adc_otr;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic. Dropping I_en returns to IDLE from anywhere.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        if (!I_en) begin
            w_next_state = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: w_next_state = (PIPE_LAT == 0) ? c_ST_RUN : c_ST_FILL;
                c_ST_FILL: begin
                    if (r_fill_cnt == c_FILL_LAST) begin
                        w_next_state = c_ST_RUN;
                    end
                end
                c_ST_RUN:  w_next_state = c_ST_RUN;
                default:   w_next_state = c_ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs. A registered sample is consumed (discarded in FILL,
    // accumulated in RUN) only while I_en is still high.
    // ------------------------------------------------------------------
    always_comb begin
        w_fill_step = 1'b0;
        w_run_step  = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            c_ST_FILL: begin
                w_fill_step = I_en;
                w_busy      = 1'b1;
            end
            c_ST_RUN: begin
                w_run_step  = I_en;
                w_busy      = 1'b1;
            end
            default: begin
                w_busy      = 1'b0;
            end
        endcase
    end

    // Counts samples discarded in FILL; zero whenever FILL is not consuming
    // so a re-enable always repeats the full discard.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fill_cnt <= '0;
        end else if (!w_fill_step || (r_fill_cnt == c_FILL_LAST)) begin
            r_fill_cnt <= '0;
        end else begin
            r_fill_cnt <= r_fill_cnt + c_FILL_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Averaging datapath. A partial window is abandoned when I_en drops;
    // a window that already completed is still delivered.
    // ------------------------------------------------------------------
    assign w_acc_clr = ~I_en;

    adc_avg_acc #(
        .ADC_W    (ADC_W),
        .ACC_LOG2 (ACC_LOG2)
    ) u_avg_acc (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_acc_clr),
        .in_vld   (w_run_step),
        .in_data  (r_adc_data),
        .in_otr   (r_adc_otr),
        .out_vld  (w_win_vld),
        .out_data (w_win_data),
        .out_otr  (w_win_otr)
    );

    // ------------------------------------------------------------------
    // Output register. A new word replaces the held one only if the held
    // one is empty or being accepted this cycle; otherwise the new word is
    // lost and the overrun flag latches until reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_o_data    <= '0;
            r_o_valid   <= 1'b0;
            r_o_otr     <= 1'b0;
            r_o_overrun <= 1'b0;
        end else if (w_win_vld) begin
            if (!r_o_valid || I_ready) begin
                r_o_data  <= w_win_data;
                r_o_otr   <= w_win_otr;
                r_o_valid <= 1'b1;
            end else begin
                r_o_overrun <= 1'b1;
            end
        end else if (r_o_valid && I_ready) begin
            r_o_valid <= 1'b0;
        end
    end

    assign O_data    = r_o_data;
    assign O_valid   = r_o_valid;
    assign O_otr     = r_o_otr;
    assign O_overrun = r_o_overrun;
    assign O_busy    = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_adc_9226_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_9226_capture
// Description : Self-checking bench. Two instances share one stimulus: one
//               averaging 4 samples, one passing every sample through.
//               Directed scenarios check against fixed values; a random run
//               checks against a sample-stream reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_9226_capture;

    localparam int c_PIPE_LAT = 7;

    logic        clk;
    logic        r_rst;
    logic        r_en;
    logic        r_ready;
    logic [11:0] r_data;
    logic        r_otr;

    logic        w_clkdrv_4, w_valid_4, w_otr_4, w_ovr_4, w_busy_4;
    logic [11:0] w_data_4;
    logic        w_clkdrv_1, w_valid_1, w_otr_1, w_ovr_1, w_busy_1;
    logic [11:0] w_data_1;

    int n_cmp  = 0;
    int n_fail = 0;

    adc_9226_capture #(.ADC_W(12), .PIPE_LAT(c_PIPE_LAT), .ACC_LOG2(2)) u_dut_avg4 (
        .clk(clk), .rst(r_rst), .I_en(r_en), .I_adc_data(r_data), .I_adc_otr(r_otr),
        .I_ready(r_ready), .O_adc_clkDriver(w_clkdrv_4), .O_data(w_data_4),
        .O_valid(w_valid_4), .O_otr(w_otr_4), .O_overrun(w_ovr_4), .O_busy(w_busy_4)
    );

    adc_9226_capture #(.ADC_W(12), .PIPE_LAT(c_PIPE_LAT), .ACC_LOG2(0)) u_dut_avg1 (
        .clk(clk), .rst(r_rst), .I_en(r_en), .I_adc_data(r_data), .I_adc_otr(r_otr),
        .I_ready(r_ready), .O_adc_clkDriver(w_clkdrv_1), .O_data(w_data_1),
        .O_valid(w_valid_1), .O_otr(w_otr_1), .O_overrun(w_ovr_1), .O_busy(w_busy_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model, index 0 = 4-sample average, index 1 = pass-through.
    // Works on the sample stream: the n-th enabled edge presents pin sample
    // n, which is consumed one edge later; samples 1..PIPE_LAT are thrown
    // away, later ones are grouped into windows, and a finished window
    // reaches the output register one edge after its last sample.
    // ------------------------------------------------------------------
    int          m_streak;
    int          m_prev_d;
    bit          m_prev_o;
    int          m_sum [2];
    int          m_cnt [2];
    bit          m_wotr[2];
    bit          m_pend[2];
    logic [11:0] m_pend_data[2];
    bit          m_pend_otr[2];
    bit          m_valid[2];
    logic [11:0] m_data[2];
    bit          m_otr[2];
    bit          m_ovr[2];

    function automatic void model_edge(bit rs, bit en, bit rdy, logic [11:0] d, bit o);
        if (rs) begin
            m_streak = 0;
            for (int i = 0; i < 2; i++) begin
                m_sum[i] = 0; m_cnt[i] = 0; m_wotr[i] = 0;
                m_pend[i] = 0; m_pend_data[i] = '0; m_pend_otr[i] = 0;
                m_valid[i] = 0; m_data[i] = '0; m_otr[i] = 0; m_ovr[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_pend[i]) begin
                    if (!m_valid[i] || rdy) begin
                        m_valid[i] = 1; m_data[i] = m_pend_data[i]; m_otr[i] = m_pend_otr[i];
                    end else begin
                        m_ovr[i] = 1;
                    end
                end else if (m_valid[i] && rdy) begin
                    m_valid[i] = 0;
                end
                m_pend[i] = 0;
            end
            if (!en) begin
                m_streak = 0;
                for (int i = 0; i < 2; i++) begin
                    m_sum[i] = 0; m_cnt[i] = 0; m_wotr[i] = 0;
                end
            end else begin
                m_streak++;
                if (m_streak > c_PIPE_LAT + 1) begin
                    for (int i = 0; i < 2; i++) begin
                        int lg;
                        lg = (i == 0) ? 2 : 0;
                        m_sum[i] += m_prev_d;
                        m_wotr[i] = m_wotr[i] | m_prev_o;
                        m_cnt[i]++;
                        if (m_cnt[i] == (1 << lg)) begin
                            m_pend[i] = 1;
                            m_pend_data[i] = 12'(m_sum[i] / (1 << lg));
                            m_pend_otr[i] = m_wotr[i];
                            m_sum[i] = 0; m_cnt[i] = 0; m_wotr[i] = 0;
                        end
                    end
                end
            end
        end
        m_prev_d = int'(d);
        m_prev_o = o;
    endfunction

    // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
    task automatic step(input bit rs, input bit en, input bit rdy, input logic [11:0] d, input bit o);
        r_rst = rs; r_en = en; r_ready = rdy; r_data = d; r_otr = o;
        @(posedge clk);
        model_edge(rs, en, rdy, d, o);
        #1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        step(1, 1, 1, 12'($urandom), 1);
        step(1, 1, 0, 12'($urandom), 1);
        n_cmp++; if (w_data_4  !== 12'd0) begin n_fail++; $display("FAIL reset_data4 got %0d want 0", w_data_4); end
        n_cmp++; if (w_valid_4 !== 1'b0)  begin n_fail++; $display("FAIL reset_valid4 got %0b want 0", w_valid_4); end
        n_cmp++; if (w_otr_4   !== 1'b0)  begin n_fail++; $display("FAIL reset_otr4 got %0b want 0", w_otr_4); end
        n_cmp++; if (w_ovr_4   !== 1'b0)  begin n_fail++; $display("FAIL reset_ovr4 got %0b want 0", w_ovr_4); end
        n_cmp++; if (w_busy_4  !== 1'b0)  begin n_fail++; $display("FAIL reset_busy4 got %0b want 0", w_busy_4); end
        n_cmp++; if (w_data_1  !== 12'd0) begin n_fail++; $display("FAIL reset_data1 got %0d want 0", w_data_1); end
        n_cmp++; if (w_valid_1 !== 1'b0)  begin n_fail++; $display("FAIL reset_valid1 got %0b want 0", w_valid_1); end
        n_cmp++; if (w_busy_1  !== 1'b0)  begin n_fail++; $display("FAIL reset_busy1 got %0b want 0", w_busy_1); end
        // ADC clock keeps running while reset is held
        n_cmp++; if (w_clkdrv_4 !== 1'b1) begin n_fail++; $display("FAIL reset_clkdrv_hi got %0b want 1", w_clkdrv_4); end
        @(negedge clk); #1;
        n_cmp++; if (w_clkdrv_1 !== 1'b0) begin n_fail++; $display("FAIL reset_clkdrv_lo got %0b want 0", w_clkdrv_1); end
        step(0, 0, 1, 12'd0, 0);
        n_cmp++; if (w_busy_4 !== 1'b0) begin n_fail++; $display("FAIL idle_busy4 got %0b want 0", w_busy_4); end
    endtask

    // Pass-through latency; sample n = 100+n, first output is sample 8.
    task automatic test_latency();
        step(1, 0, 1, 12'd0, 0);
        for (int k = 1; k <= 17; k++) begin
            bit e1, e4;
            step(0, 1, 1, 12'(100 + k), 0);
            e1 = (k >= 10);
            e4 = (k == 13) || (k == 17);
            n_cmp++; if (w_busy_1 !== 1'b1) begin n_fail++; $display("FAIL lat_busy k=%0d got %0b want 1", k, w_busy_1); end
            n_cmp++; if (w_valid_1 !== e1) begin n_fail++; $display("FAIL lat_valid1 k=%0d got %0b want %0b", k, w_valid_1, e1); end
            if (e1) begin
                n_cmp++; if (w_data_1 !== 12'(100 + k - 2)) begin n_fail++; $display("FAIL lat_data1 k=%0d got %0d want %0d", k, w_data_1, 100 + k - 2); end
            end
            n_cmp++; if (w_valid_4 !== e4) begin n_fail++; $display("FAIL lat_valid4 k=%0d got %0b want %0b", k, w_valid_4, e4); end
            if (k == 13) begin
                n_cmp++; if (w_data_4 !== 12'd109) begin n_fail++; $display("FAIL lat_data4a got %0d want 109", w_data_4); end
            end
            if (k == 17) begin
                n_cmp++; if (w_data_4 !== 12'd113) begin n_fail++; $display("FAIL lat_data4b got %0d want 113", w_data_4); end
            end
        end
    endtask

    // 100,104,108,112 after the fill -> 106 for exactly one cycle.
    task automatic test_avg();
        step(1, 0, 1, 12'd0, 0);
        for (int k = 1; k <= 15; k++) begin
            bit in_win;
            in_win = (k >= 8) && (k <= 11);
            step(0, 1, 1, in_win ? 12'(100 + 4 * (k - 8)) : 12'($urandom), in_win ? 1'b0 : 1'($urandom));
            n_cmp++; if (w_valid_4 !== (k == 13)) begin n_fail++; $display("FAIL avg_valid k=%0d got %0b want %0b", k, w_valid_4, (k == 13)); end
            if (k == 13) begin
                n_cmp++; if (w_data_4 !== 12'd106) begin n_fail++; $display("FAIL avg_data got %0d want 106", w_data_4); end
                n_cmp++; if (w_otr_4 !== 1'b0) begin n_fail++; $display("FAIL avg_otr got %0b want 0", w_otr_4); end
            end
        end
    endtask

    // OTR on the third sample of a full-scale window, then a clean window.
    task automatic test_otr();
        step(1, 0, 1, 12'd0, 0);
        for (int k = 1; k <= 17; k++) begin
            logic [11:0] d;
            bit          o;
            if (k < 8) begin d = 12'($urandom); o = 1; end
            else if (k <= 11) begin d = 12'd4095; o = (k == 10); end
            else if (k <= 15) begin d = 12'h800; o = 0; end
            else begin d = 12'd0; o = 0; end
            step(0, 1, 1, d, o);
            n_cmp++; if (w_valid_4 !== ((k == 13) || (k == 17))) begin n_fail++; $display("FAIL otr_valid k=%0d got %0b", k, w_valid_4); end
            if (k == 13) begin
                n_cmp++; if (w_data_4 !== 12'd4095) begin n_fail++; $display("FAIL otr_data1 got %0d want 4095", w_data_4); end
                n_cmp++; if (w_otr_4 !== 1'b1) begin n_fail++; $display("FAIL otr_flag1 got %0b want 1", w_otr_4); end
            end
            if (k == 17) begin
                n_cmp++; if (w_data_4 !== 12'h800) begin n_fail++; $display("FAIL otr_data2 got %0d want 2048", w_data_4); end
                n_cmp++; if (w_otr_4 !== 1'b0) begin n_fail++; $display("FAIL otr_flag2 got %0b want 0", w_otr_4); end
            end
        end
    endtask

    // Pass-through with I_ready low for three samples.
    task automatic test_overrun();
        step(1, 0, 1, 12'd0, 0);
        for (int k = 1; k <= 18; k++) begin
            step(0, 1, !((k >= 11) && (k <= 13)), 12'(200 + k), 0);
            if (k == 10) begin
                n_cmp++; if (w_data_1 !== 12'd208 || w_ovr_1 !== 1'b0) begin n_fail++; $display("FAIL ovr_first got %0d/%0b want 208/0", w_data_1, w_ovr_1); end
            end
            if (k >= 11 && k <= 13) begin
                n_cmp++; if (w_data_1 !== 12'd208) begin n_fail++; $display("FAIL ovr_hold k=%0d got %0d want 208", k, w_data_1); end
                n_cmp++; if (w_valid_1 !== 1'b1) begin n_fail++; $display("FAIL ovr_valid k=%0d got %0b want 1", k, w_valid_1); end
            end
            if (k == 14) begin
                n_cmp++; if (w_data_1 !== 12'd212) begin n_fail++; $display("FAIL ovr_resume got %0d want 212", w_data_1); end
            end
            if (k >= 11) begin
                n_cmp++; if (w_ovr_1 !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky k=%0d got %0b want 1", k, w_ovr_1); end
            end
        end
        step(1, 1, 1, 12'd0, 0);
        n_cmp++; if (w_ovr_1 !== 1'b0) begin n_fail++; $display("FAIL ovr_clear got %0b want 0", w_ovr_1); end
    endtask

    // Window abandoned after two samples; re-enable repeats the fill.
    task automatic test_partial();
        step(1, 0, 1, 12'd0, 0);
        for (int k = 1; k <= 10; k++) begin
            step(0, 1, 1, (k >= 8) ? 12'd4000 : 12'($urandom), (k >= 8));
            n_cmp++; if (w_valid_4 !== 1'b0) begin n_fail++; $display("FAIL part_a_valid k=%0d got %0b want 0", k, w_valid_4); end
        end
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 1, 12'($urandom), 1);
            n_cmp++; if (w_valid_4 !== 1'b0 || w_busy_4 !== 1'b0) begin n_fail++; $display("FAIL part_idle got valid=%0b busy=%0b want 0/0", w_valid_4, w_busy_4); end
        end
        for (int k = 1; k <= 14; k++) begin
            bit in_win;
            in_win = (k >= 8) && (k <= 11);
            step(0, 1, 1, in_win ? 12'(20 * (k - 7)) : 12'(4000), 0);
            n_cmp++; if (w_valid_4 !== (k == 13)) begin n_fail++; $display("FAIL part_b_valid k=%0d got %0b", k, w_valid_4); end
            if (k == 13) begin
                n_cmp++; if (w_data_4 !== 12'd50 || w_otr_4 !== 1'b0) begin n_fail++; $display("FAIL part_b_data got %0d/%0b want 50/0", w_data_4, w_otr_4); end
            end
        end
    endtask

    // Reset while a word is held, then the fill must repeat.
    task automatic test_rst_mid_run();
        logic [11:0] samp[16];
        step(1, 0, 1, 12'd0, 0);
        for (int k = 1; k <= 12; k++) step(0, 1, 1, 12'($urandom), 1'($urandom));
        n_cmp++; if (w_valid_1 !== 1'b1) begin n_fail++; $display("FAIL rmr_pre_valid got %0b want 1", w_valid_1); end
        step(1, 1, 1, 12'($urandom), 1);
        n_cmp++; if (w_valid_1 !== 1'b0 || w_data_1 !== 12'd0 || w_otr_1 !== 1'b0) begin n_fail++; $display("FAIL rmr_out1 got v=%0b d=%0d o=%0b want 0", w_valid_1, w_data_1, w_otr_1); end
        n_cmp++; if (w_valid_4 !== 1'b0 || w_data_4 !== 12'd0 || w_otr_4 !== 1'b0) begin n_fail++; $display("FAIL rmr_out4 got v=%0b d=%0d o=%0b want 0", w_valid_4, w_data_4, w_otr_4); end
        n_cmp++; if (w_busy_1 !== 1'b0 || w_busy_4 !== 1'b0 || w_ovr_1 !== 1'b0) begin n_fail++; $display("FAIL rmr_busy got %0b/%0b ovr %0b want 0", w_busy_1, w_busy_4, w_ovr_1); end
        for (int k = 1; k <= 11; k++) begin
            samp[k] = 12'($urandom);
            step(0, 1, 1, samp[k], 0);
            n_cmp++; if (w_valid_1 !== (k >= 10)) begin n_fail++; $display("FAIL rmr_refill k=%0d got %0b want %0b", k, w_valid_1, (k >= 10)); end
            if (k >= 10) begin
                n_cmp++; if (w_data_1 !== samp[k - 2]) begin n_fail++; $display("FAIL rmr_data k=%0d got %0d want %0d", k, w_data_1, samp[k - 2]); end
            end
        end
    endtask

    // Random enable/ready/reset traffic against the reference model.
    task automatic test_random();
        bit en;
        en = 1;
        step(1, 0, 1, 12'd0, 0);
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 39) == 0) en = !en;
            step($urandom_range(0, 299) == 0, en, $urandom_range(0, 3) != 0,
                 12'($urandom), $urandom_range(0, 7) == 0);
            n_cmp++; if (w_valid_4 !== m_valid[0]) begin n_fail++; $display("FAIL rnd_valid4 c=%0d got %0b want %0b", c, w_valid_4, m_valid[0]); end
            n_cmp++; if (w_data_4  !== m_data[0])  begin n_fail++; $display("FAIL rnd_data4 c=%0d got %0d want %0d", c, w_data_4, m_data[0]); end
            n_cmp++; if (w_otr_4   !== m_otr[0])   begin n_fail++; $display("FAIL rnd_otr4 c=%0d got %0b want %0b", c, w_otr_4, m_otr[0]); end
            n_cmp++; if (w_ovr_4   !== m_ovr[0])   begin n_fail++; $display("FAIL rnd_ovr4 c=%0d got %0b want %0b", c, w_ovr_4, m_ovr[0]); end
            n_cmp++; if (w_busy_4  !== (m_streak > 0)) begin n_fail++; $display("FAIL rnd_busy4 c=%0d got %0b want %0b", c, w_busy_4, (m_streak > 0)); end
            n_cmp++; if (w_valid_1 !== m_valid[1]) begin n_fail++; $display("FAIL rnd_valid1 c=%0d got %0b want %0b", c, w_valid_1, m_valid[1]); end
            n_cmp++; if (w_data_1  !== m_data[1])  begin n_fail++; $display("FAIL rnd_data1 c=%0d got %0d want %0d", c, w_data_1, m_data[1]); end
            n_cmp++; if (w_otr_1   !== m_otr[1])   begin n_fail++; $display("FAIL rnd_otr1 c=%0d got %0b want %0b", c, w_otr_1, m_otr[1]); end
            n_cmp++; if (w_ovr_1   !== m_ovr[1])   begin n_fail++; $display("FAIL rnd_ovr1 c=%0d got %0b want %0b", c, w_ovr_1, m_ovr[1]); end
            n_cmp++; if (w_busy_1  !== (m_streak > 0)) begin n_fail++; $display("FAIL rnd_busy1 c=%0d got %0b want %0b", c, w_busy_1, (m_streak > 0)); end
        end
    endtask

    initial begin
        r_rst = 1'b1; r_en = 1'b0; r_ready = 1'b0; r_data = '0; r_otr = 1'b0;
        m_streak = 0; m_prev_d = 0; m_prev_o = 0;
        #2;
        test_reset();
        test_latency();
        test_avg();
        test_otr();
        test_overrun();
        test_partial();
        test_rst_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
